// File: rtl/crc8_frame_ctrl.sv
// Round-robin frame controller for two byte requesters feeding a bit-serial CRC-8 engine (poly 0xAB, MSB-first).
// Optional macro CRC8_CHECK_EN adds the res_ok output (final CRC equals zero, for receive-side checking).
module crc8_frame_ctrl #(
    parameter logic [7:0] CRC_INIT   = 8'h00,
    parameter bit         PRIO_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_crc,
    output logic       res_id,
    output logic       busy
`ifdef CRC8_CHECK_EN
    ,
    output logic       res_ok
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        GET,
        SHIFT,
        DONE
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       grant;
    logic       prio;
    logic [7:0] crc;
    logic [7:0] sh;
    logic       lst;
    logic [2:0] bitcnt;

    logic       any_valid;
    logic       pick;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       accept;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((b ^ c[7]) ? 8'hAB : 8'h00);
    endfunction

    // The priority holder wins a tie; otherwise whoever is requesting gets the grant.
    assign any_valid = s0_valid | s1_valid;
    assign pick      = prio ? s1_valid : ~s0_valid;
    assign sel_valid = grant ? s1_valid : s0_valid;
    assign sel_data  = grant ? s1_data  : s0_data;
    assign sel_last  = grant ? s1_last  : s0_last;
    assign accept    = (state == GET) && sel_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_valid) next_state = GET;
            GET:     if (accept) next_state = SHIFT;
            SHIFT:   if (bitcnt == 3'd0) next_state = lst ? DONE : GET;
            DONE:    if (res_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant  <= 1'b0;
            prio   <= PRIO_FIRST;
            crc    <= CRC_INIT;
            sh     <= 8'h00;
            lst    <= 1'b0;
            bitcnt <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant <= pick;
                        crc   <= CRC_INIT;
                    end
                end
                GET: begin
                    if (accept) begin
                        sh     <= sel_data;
                        lst    <= sel_last;
                        bitcnt <= 3'd7;
                    end
                end
                SHIFT: begin
                    crc    <= crc_step(crc, sh[bitcnt]);
                    bitcnt <= bitcnt - 3'd1;
                end
                DONE: begin
                    if (res_ready) prio <= ~grant;
                end
                default: ;
            endcase
        end
    end

    // Everything the requesters and consumer see is a pure decode of registered state.
    always_comb begin
        s0_ready  = (state == GET) && !grant;
        s1_ready  = (state == GET) && grant;
        res_valid = (state == DONE);
        res_crc   = (state == DONE) ? crc : 8'h00;
        res_id    = (state == DONE) && grant;
        busy      = (state != IDLE);
`ifdef CRC8_CHECK_EN
        res_ok    = (state == DONE) && (crc == 8'h00);
`endif
    end

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// Self-checking bench for crc8_frame_ctrl: directed vectors plus randomized two-requester traffic
// against a byte-wise CRC model and per-requester expected-result queues.
module tb_crc8_frame_ctrl;

    typedef logic [7:0] byteq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s0_data = 8'h00;
    logic       s0_valid = 1'b0;
    logic       s0_last = 1'b0;
    logic       s0_ready;
    logic [7:0] s1_data = 8'h00;
    logic       s1_valid = 1'b0;
    logic       s1_last = 1'b0;
    logic       s1_ready;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_crc;
    logic       res_id;
    logic       busy;
`ifdef CRC8_CHECK_EN
    logic       res_ok;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    logic [8:0] strm0[$];
    logic [8:0] strm1[$];
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic       got_ids[$];
    int         rdy_cyc0[$];
    int         rdy_cyc1[$];

    crc8_frame_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s0_data   (s0_data),
        .s0_valid  (s0_valid),
        .s0_last   (s0_last),
        .s0_ready  (s0_ready),
        .s1_data   (s1_data),
        .s1_valid  (s1_valid),
        .s1_last   (s1_last),
        .s1_ready  (s1_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_crc   (res_crc),
        .res_id    (res_id),
        .busy      (busy)
`ifdef CRC8_CHECK_EN
        ,
        .res_ok    (res_ok)
`endif
    );

    always #5 clk = ~clk;

    // Byte-at-a-time CRC: xor the byte into the register, then eight polynomial divisions.
    function automatic logic [7:0] model_crc(input byteq_t b);
        logic [7:0] c;
        c = 8'h00;
        foreach (b[i]) begin
            c = c ^ b[i];
            for (int k = 0; k < 8; k++) c = c[7] ? (8'(c << 1) ^ 8'hAB) : 8'(c << 1);
        end
        return c;
    endfunction

    task automatic add_frame(input int p, input byteq_t b);
        logic [8:0] w;
        for (int i = 0; i < b.size(); i++) begin
            w = {(i == b.size() - 1), b[i]};
            if (p == 0) strm0.push_back(w);
            else        strm1.push_back(w);
        end
        if (p == 0) exp0.push_back(model_crc(b));
        else        exp1.push_back(model_crc(b));
    endtask

    task automatic drive_inputs();
        s0_valid = (strm0.size() != 0);
        if (s0_valid) {s0_last, s0_data} = strm0[0];
        else begin s0_last = 1'b0; s0_data = 8'h00; end
        s1_valid = (strm1.size() != 0);
        if (s1_valid) {s1_last, s1_data} = strm1[0];
        else begin s1_last = 1'b0; s1_data = 8'h00; end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        s0_valid = 1'b0; s0_data = 8'h00; s0_last = 1'b0;
        s1_valid = 1'b0; s1_data = 8'h00; s1_last = 1'b0;
        res_ready = 1'b0;
        strm0.delete(); strm1.delete(); exp0.delete(); exp1.delete();
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs queued frames to completion; checks results, exclusivity of READY and result stability.
    task automatic run_traffic(input int budget, input bit rand_rdy);
        int         cyc;
        logic       pend;
        logic [7:0] pcrc;
        logic       pid;
        logic [7:0] e;
        cyc = 0;
        pend = 1'b0;
        pcrc = 8'h00;
        pid = 1'b0;
        got_ids.delete(); rdy_cyc0.delete(); rdy_cyc1.delete();
        while ((strm0.size() != 0 || strm1.size() != 0 || exp0.size() != 0 || exp1.size() != 0) && cyc < budget) begin
            drive_inputs();
            res_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            n_cmp++;
            if (s0_ready && s1_ready) begin
                n_fail++;
                $display("[TB] FAIL both_ready: s0_ready=%b s1_ready=%b required not both 1", s0_ready, s1_ready);
            end
            if (pend) begin
                n_cmp++;
                if (res_valid !== 1'b1 || res_crc !== pcrc || res_id !== pid) begin
                    n_fail++;
                    $display("[TB] FAIL result_hold: got v=%b crc=%h id=%b, required v=1 crc=%h id=%b",
                             res_valid, res_crc, res_id, pcrc, pid);
                end
            end
            if (s0_ready) rdy_cyc0.push_back(cyc);
            if (s1_ready) rdy_cyc1.push_back(cyc);
            if (s0_valid && s0_ready) void'(strm0.pop_front());
            if (s1_valid && s1_ready) void'(strm1.pop_front());
            if (res_valid && res_ready) begin
                n_cmp++;
                if ((res_id === 1'b0 && exp0.size() == 0) || (res_id === 1'b1 && exp1.size() == 0) || $isunknown(res_id)) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_result: got id=%b crc=%h, required no result", res_id, res_crc);
                end else begin
                    e = (res_id == 1'b0) ? exp0.pop_front() : exp1.pop_front();
                    if (res_crc !== e) begin
                        n_fail++;
                        $display("[TB] FAIL result_crc: id=%b got %h, required %h", res_id, res_crc, e);
                    end
`ifdef CRC8_CHECK_EN
                    n_cmp++;
                    if (res_ok !== (e == 8'h00)) begin
                        n_fail++;
                        $display("[TB] FAIL res_ok: got %b, required %b", res_ok, (e == 8'h00));
                    end
`endif
                end
                got_ids.push_back(res_id);
            end
            pend = res_valid && !res_ready;
            pcrc = res_crc;
            pid  = res_id;
            @(posedge clk);
            #1;
            cyc++;
        end
        n_cmp++;
        if (strm0.size() != 0 || strm1.size() != 0 || exp0.size() != 0 || exp1.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL traffic_timeout: got %0d bytes / %0d results pending after %0d cycles, required 0",
                     strm0.size() + strm1.size(), exp0.size() + exp1.size(), cyc);
            strm0.delete(); strm1.delete(); exp0.delete(); exp1.delete();
        end
        drive_inputs();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({s0_ready, s1_ready, res_valid, res_id, busy, res_crc} !== 13'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got rdy=%b%b v=%b id=%b busy=%b crc=%h, required all 0",
                     s0_ready, s1_ready, res_valid, res_id, busy, res_crc);
        end
`ifdef CRC8_CHECK_EN
        n_cmp++;
        if (res_ok !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_res_ok: got %b, required 0", res_ok);
        end
`endif
        release_reset();
        @(negedge clk);
        n_cmp++;
        if ({s0_ready, s1_ready, res_valid, busy} !== 4'h0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got rdy=%b%b v=%b busy=%b, required all 0",
                     s0_ready, s1_ready, res_valid, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_byte();
        int rdy_n[$];
        int early;
        early = 0;
        res_ready = 1'b1;
        s0_valid = 1'b1; s0_data = 8'h01; s0_last = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (n == 1) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL busy_idle: got %b, required 0", busy);
                end
            end
            if (s0_ready) rdy_n.push_back(n);
            if (n < 11 && res_valid) early++;
            if (n == 11) begin
                n_cmp++;
                if (res_valid !== 1'b1 || res_crc !== 8'hAB || res_id !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL single_byte: got v=%b crc=%h id=%b, required v=1 crc=ab id=0",
                             res_valid, res_crc, res_id);
                end
`ifdef CRC8_CHECK_EN
                n_cmp++;
                if (res_ok !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL single_res_ok: got %b, required 0", res_ok);
                end
`endif
            end
            @(posedge clk);
            #1;
            if (rdy_n.size() != 0) s0_valid = 1'b0;
        end
        n_cmp++;
        if (early != 0) begin
            n_fail++;
            $display("[TB] FAIL res_valid_early: got %0d early cycles, required 0", early);
        end
        n_cmp++;
        if (rdy_n.size() != 1 || rdy_n[0] != 2) begin
            n_fail++;
            $display("[TB] FAIL ready_timing: got %0d pulses first at %0d, required 1 pulse at 2",
                     rdy_n.size(), (rdy_n.size() != 0) ? rdy_n[0] : -1);
        end
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL after_consume: got v=%b busy=%b, required 0 0", res_valid, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_s1_frame();
        byteq_t fr;
        fr.push_back(8'h02);
        n_cmp++;
        if (model_crc(fr) !== 8'hFD) begin
            n_fail++;
            $display("[TB] FAIL model_02: got %h, required fd", model_crc(fr));
        end
        add_frame(1, fr);
        run_traffic(100, 1'b0);
        n_cmp++;
        if (rdy_cyc0.size() != 0 || got_ids.size() != 1 || got_ids[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL s1_frame: got s0 ready pulses %0d results %0d, required 0 and one id=1",
                     rdy_cyc0.size(), got_ids.size());
        end
    endtask

    task automatic test_two_byte();
        byteq_t fr;
        fr.push_back(8'h01);
        fr.push_back(8'hAB);
        add_frame(0, fr);
        run_traffic(100, 1'b0);
        n_cmp++;
        if (rdy_cyc0.size() != 2 || (rdy_cyc0[1] - rdy_cyc0[0]) != 9) begin
            n_fail++;
            $display("[TB] FAIL two_byte_ready: got %0d pulses, required 2 pulses 9 cycles apart", rdy_cyc0.size());
        end
    endtask

    task automatic test_round_robin();
        byteq_t a, b, c;
        apply_reset();
        release_reset();
        a.push_back(8'($urandom));
        b.push_back(8'($urandom));
        b.push_back(8'($urandom));
        c.push_back(8'($urandom));
        add_frame(0, a);
        add_frame(0, b);
        add_frame(1, c);
        run_traffic(300, 1'b0);
        n_cmp++;
        if (got_ids.size() != 3 || got_ids[0] !== 1'b0 || got_ids[1] !== 1'b1 || got_ids[2] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL round_robin: got %0d results, required order 0,1,0", got_ids.size());
        end
    endtask

    task automatic test_hold_result();
        byteq_t fr, f0;
        int idx;
        logic acc, got;
        logic [7:0] e;
        idx = 0;
        got = 1'b0;
        apply_reset();
        release_reset();
        fr.push_back(8'($urandom));
        fr.push_back(8'($urandom));
        e = model_crc(fr);
        f0.push_back(8'h5A);
        res_ready = 1'b0;
        s1_valid = 1'b1; s1_data = fr[0]; s1_last = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            acc = s1_valid && s1_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx == 1) begin
                    s1_data = fr[1]; s1_last = 1'b1;
                    add_frame(0, f0);
                    s0_valid = 1'b1; s0_data = 8'h5A; s0_last = 1'b1;
                end else begin
                    s1_valid = 1'b0;
                end
            end
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("[TB] FAIL hold_timeout: got no res_valid, required one within 100 cycles");
        end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (res_valid !== 1'b1 || res_crc !== e || res_id !== 1'b1 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL hold_stable: cycle %0d got v=%b crc=%h id=%b rdy=%b%b, required v=1 crc=%h id=1 rdy=00",
                         k, res_valid, res_crc, res_id, s0_ready, s1_ready, e);
            end
            if (k < 5) begin
                @(posedge clk);
                #1;
                @(negedge clk);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        run_traffic(100, 1'b0);
        n_cmp++;
        if (got_ids.size() != 1 || got_ids[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stalled_served: got %0d results, required one id=0", got_ids.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        byteq_t fr, z;
        int nacc;
        logic acc;
        nacc = 0;
        apply_reset();
        release_reset();
        fr.push_back(8'h11); fr.push_back(8'h22); fr.push_back(8'h33);
        res_ready = 1'b1;
        s0_valid = 1'b1; s0_data = fr[0]; s0_last = 1'b0;
        for (int c = 0; c < 100 && nacc < 2; c++) begin
            @(negedge clk);
            acc = s0_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                nacc++;
                s0_data = fr[nacc];
                s0_last = (nacc == 2);
            end
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (nacc != 2 || {s0_ready, s1_ready, res_valid, res_id, busy, res_crc} !== 13'h0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: accepts=%0d got rdy=%b%b v=%b id=%b busy=%b crc=%h, required 2 and all 0",
                     nacc, s0_ready, s1_ready, res_valid, res_id, busy, res_crc);
        end
        s0_valid = 1'b0; s0_last = 1'b0;
        release_reset();
        z.push_back(8'h00);
        add_frame(0, z);
        run_traffic(100, 1'b0);
        n_cmp++;
        if (got_ids.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL post_reset_frame: got %0d results, required 1", got_ids.size());
        end
    endtask

    task automatic test_random();
        byteq_t fr;
        int nf, len;
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < 2; p++) begin
                nf = $urandom_range(1, 3);
                for (int f = 0; f < nf; f++) begin
                    fr.delete();
                    len = $urandom_range(1, 4);
                    for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
                    add_frame(p, fr);
                end
            end
            run_traffic(3000, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_s1_frame();
        test_two_byte();
        test_round_robin();
        test_hold_result();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/crc8_frame_ctrl.md
# crc8_frame_ctrl

Frame-level controller and arbiter for the bit-serial CRC-8 engine (polynomial 0xAB, x^8+x^7+x^5+x^3+x+1, MSB-first). It accepts byte frames from two requesters, grants the single CRC datapath to one frame at a time (round-robin), and serializes each byte into the engine one bit per clock. When a frame ends, it presents the 8-bit result tagged with the requester ID. It sits between the byte-oriented packet logic and the serial CRC datapath, which is embedded here as an internal shift register.

## Interface
- CRC_INIT, 8'h00, CRC register value loaded at the start of every frame
- PRIO_FIRST, 0, requester (0 or 1) that holds priority after reset
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- S0_DATA  in  8  requester 0 byte
- S0_VALID  in  1  requester 0 byte valid
- S0_LAST  in  1  byte is the last of requester 0's frame
- S0_READY  out  1  requester 0 byte accepted this cycle
- S1_DATA / S1_VALID / S1_LAST / S1_READY: same as S0_*, for requester 1
- RES_VALID  out  1  result available
- RES_READY  in  1  result consumer accepts
- RES_CRC  out  8  final CRC of the frame
- RES_ID  out  1  requester that owned the frame
- RES_OK  out  1  RES_CRC == 8'h00; exists only with CRC8_CHECK_EN
- BUSY  out  1  state != IDLE

## Operation
- Engine step, with bit b: inv = b ^ crc[7]; crc <= {crc[6:0],1'b0} ^ (inv ? 8'hAB : 8'h00). This is one step per clock.
- State IDLE:
  - If either S*_VALID is high: grant = the requester with priority if its VALID is high, else the other requester.
  - Load crc <= CRC_INIT and go to GET.
- State GET:
  - READY of the granted port = 1. The other port's READY = 0.
  - On VALID&&READY: latch the byte into sh and LAST into lst, set bitcnt = 7, go to SHIFT.
  - Otherwise stay in GET. The block has no timeout.
- State SHIFT:
  - Each cycle feeds sh[bitcnt] into the engine and decrements bitcnt.
  - After the step with bitcnt = 0: if lst, go to DONE; else go to GET.
- State DONE:
  - RES_VALID = 1. RES_CRC = crc. RES_ID = grant.
  - On RES_READY: go to IDLE and give priority to the requester not granted (!grant).
- Requesters must hold VALID, DATA and LAST stable until READY. The block does not check this.
- The non-granted requester is stalled (READY = 0) for the whole frame, including DONE.
- A frame is at least one byte. A one-byte frame has LAST high on its only byte.

## Timing
- Reset (async, RESET_N low) values:
  - state = IDLE, crc = CRC_INIT, priority = PRIO_FIRST.
  - S0_READY = S1_READY = 0, RES_VALID = 0, RES_CRC = 8'h00, RES_ID = 0, BUSY = 0, RES_OK = 0.
- Reset mid-frame aborts the frame. No result is produced. Both READYs drop immediately.
- READY is a registered-state decode (GET && granted), not combinational from VALID.
- Per byte: 1 GET accept cycle + 8 SHIFT cycles = 9 cycles minimum.
- Frame of N bytes with VALID always high: IDLE→GET takes 1 cycle, then N×9 cycles. RES_VALID rises in cycle 9N+2 counted from the first IDLE cycle with VALID (cycle 1).
- RES_CRC and RES_ID are held stable while RES_VALID && !RES_READY.
- Back-to-back frames: DONE→IDLE takes 1 cycle. The next grant is evaluated in that IDLE cycle.
- Simultaneous S0_VALID and S1_VALID in IDLE: the priority holder wins. The loser is served next if it still requests.

## Configuration
- CRC8_CHECK_EN defined:
  - Port RES_OK exists and equals (crc == 8'h00) in DONE; it is 0 otherwise.
  - Used for receive-side checking, where the frame includes its transmitted CRC byte.
- CRC8_CHECK_EN undefined:
  - RES_OK and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then S0 frame {0x01} with LAST → RES_CRC = 0xAB, RES_ID = 0, RES_VALID in cycle 11 (9N+2 with N = 1); with the macro, RES_OK = 0.
- S1 frame {0x02} → RES_CRC = 0xFD, RES_ID = 1; S0_READY stays 0 throughout.
- S0 frame {0x01, 0xAB} (with CRC8_CHECK_EN) → RES_CRC = 0x00, RES_OK = 1; S0_READY pulses exactly twice, 9 cycles apart.
- S0 and S1 both valid from reset with PRIO_FIRST = 0 → S0 frame served first, then S1, then S0 again if re-requested (round-robin).
- Hold RES_READY = 0 for 5 cycles in DONE → RES_VALID, RES_CRC and RES_ID stay stable, and no READY is asserted on either port.
- Assert RESET_N = 0 during SHIFT of byte 2 → all outputs return to reset values asynchronously; the next frame {0x00} yields RES_CRC = 0x00 with no carry-over.
